// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host transmitter state encodings, keyboard command bytes
// and the frame builder used when a command is latched.
package ps2_host_tx_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    // Bits after the start bit, shifted out LSB first: data, odd parity, stop.
    function automatic ps2_frame_t ps2_build_frame(input logic [7:0] data);
        ps2_frame_t f;
        f.stop   = 1'b1;
        f.parity = ~^data;
        f.data   = data;
        return f;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// PS/2 line conditioning: 2-FF sync on both pads, FILT_LEN-sample glitch filter on the
// clock line and a 1-cycle fall pulse on each accepted 1->0 clock transition.
module ps2_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_filt_o,
    output logic clk_fall_o,
    output logic data_sync_o
);

    localparam int CW = $clog2(FILT_LEN) + 1;

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_filt_q, clk_filt_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] filt_cnt_q, filt_cnt_d;

    // A new level is taken only after FILT_LEN consecutive samples that disagree
    // with the current filtered level; any agreeing sample restarts the count.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_sync_q[1] == clk_filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == CW'(FILT_LEN - 1)) begin
            clk_filt_d = clk_sync_q[1];
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fall_d = clk_filt_q & ~clk_filt_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            fall_q      <= 1'b0;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_filt_q  <= clk_filt_d;
            fall_q      <= fall_d;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign clk_filt_o  = clk_filt_q;
    assign clk_fall_o  = fall_q;
    assign data_sync_o = data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame clocked
// by the device, ACK check and line-idle wait, with a per-edge timeout.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILT_LEN       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [2:0]    state_q, state_d;
    ps2_frame_t    shreg_q, shreg_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          data_oe_q, data_oe_d;
    logic          done_d, err_d;

    logic          clk_filt, clk_fall, data_sync;
    logic          tmo_hit;

    ps2_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk_i       (clk),
        .rst_i       (rst),
        .ps2_clk_i   (ps2_clk_in),
        .ps2_data_i  (ps2_data_in),
        .clk_filt_o  (clk_filt),
        .clk_fall_o  (clk_fall),
        .data_sync_o (data_sync)
    );

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        inh_d     = inh_q;
        tmo_d     = tmo_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shreg_d = ps2_build_frame(tx_data);
                    inh_d   = '0;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    state_d = ST_REQ;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            ST_REQ: begin
                // Start bit stays on the line until the device's first falling edge.
                data_oe_d = 1'b1;
                bit_cnt_d = '0;
                tmo_d     = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (clk_fall) begin
                    tmo_d     = '0;
                    data_oe_d = ~shreg_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end else if (tmo_hit) begin
                    err_d     = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    tmo_d = '0;
                    if (!data_sync) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_filt && data_sync) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            inh_q     <= '0;
            tmo_q     <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            inh_q     <= inh_d;
            tmo_q     <= tmo_d;
            data_oe_q <= data_oe_d;
        end
    end

    // Pulses coincide with the move to IDLE; a reset in flight suppresses them.
    assign tx_done     = done_d & ~rst;
    assign tx_error    = err_d & ~rst;
    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ps2_clk_oe  = (state_q == ST_INHIBIT);
    assign ps2_data_oe = (state_q == ST_REQ) | ((state_q == ST_SEND) & data_oe_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model clocks frames and drives ACK/NACK;
// a scoreboard queue holds the expected outcome of every issued command.
module tb_ps2_host_tx;

    localparam int INH = 300;
    localparam int TMO = 2000;
    localparam int H   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILT_LEN       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       is_done;
        logic       chk_bits;
        logic [9:0] bits;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] dev_bits = '0;

    // Scoreboard monitor: every done/error pulse must match the oldest pending expectation.
    initial begin : sb_monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (tx_done || tx_error) begin
                check("pulse_exclusive", 32'(tx_done & tx_error), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b error=%0b with nothing pending", tx_done, tx_error);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_done", 32'(tx_done), 32'(e.is_done));
                    if (e.chk_bits) check("frame_bits", 32'(dev_bits), 32'(e.bits));
                end
                @(posedge clk); #1;
                check("pulse_single", 32'(tx_done | tx_error), 32'd0);
                check("ready_after_pulse", 32'(tx_ready), 32'd1);
            end
        end
    end

    // Line monitor: inhibit length, REQ shape and that each frame starts from IDLE.
    int   frame_cnt = 0;
    int   req_cyc = 0;
    int   run = 0;
    logic prev_ready = 1'b1;
    logic prev_clk_oe = 1'b0;
    initial begin : oe_monitor
        forever begin
            @(posedge clk); #1;
            if (ps2_clk_oe && !prev_clk_oe) begin
                check("start_after_ready", 32'(prev_ready), 32'd1);
                frame_cnt++;
                run = 0;
            end
            if (ps2_clk_oe) run++;
            if (!ps2_clk_oe && prev_clk_oe) begin
                check("inhibit_len", 32'(run), 32'(INH));
                check("req_data_oe", 32'(ps2_data_oe), 32'd1);
                req_cyc = cyc;
            end
            prev_ready  = tx_ready;
            prev_clk_oe = ps2_clk_oe;
        end
    end

    // Device model: waits for request-to-send, clocks nfalls bits sampling on rising
    // edges, then (for a full frame) clocks the ACK bit, pulling data low if ack=1.
    task automatic dev_frame(input int nfalls, input bit ack);
        int w;
        w = 0;
        while (!(clk_line && !data_line) && w < INH + 200) begin
            @(negedge clk);
            w++;
        end
        if (!(clk_line && !data_line)) begin
            checks++;
            errors++;
            $display("FAIL dev_wait_req: no request-to-send within %0d cycles", w);
            return;
        end
        repeat (H) @(negedge clk);
        for (int i = 0; i < nfalls; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i < 10) dev_bits[i] = data_line;
            repeat (H) @(negedge clk);
        end
        if (nfalls < 10) return;
        if (ack) dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check(name, 32'(tx_ready), 32'd1);
    endtask

    function automatic exp_t mk(input logic is_done, input logic chk, input logic [9:0] bits);
        exp_t e;
        e.is_done  = is_done;
        e.chk_bits = chk;
        e.bits     = bits;
        return e;
    endfunction

    initial begin : stimulus
        int f0;
        int w;
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Set-LEDs: bits 1,0,1,1,0,1,1,1 then parity 1, stop 1.
        exp_q.push_back(mk(1'b1, 1'b1, 10'h3ED));
        send_cmd(8'hED);
        dev_frame(10, 1'b1);
        wait_ready("t1_ready");
        repeat (5) @(negedge clk);

        exp_q.push_back(mk(1'b1, 1'b1, 10'h3FF));
        send_cmd(8'hFF);
        dev_frame(10, 1'b1);
        wait_ready("t2a_ready");
        repeat (5) @(negedge clk);

        exp_q.push_back(mk(1'b1, 1'b1, 10'h300));
        send_cmd(8'h00);
        dev_frame(10, 1'b1);
        wait_ready("t2b_ready");
        repeat (5) @(negedge clk);

        // NACK: device leaves data high on the ACK clock.
        exp_q.push_back(mk(1'b0, 1'b1, 10'h3ED));
        send_cmd(8'hED);
        dev_frame(10, 1'b0);
        wait_ready("t3_ready");
        repeat (5) @(negedge clk);

        // Silent device: error lands TMO cycles after the REQ cycle.
        exp_q.push_back(mk(1'b0, 1'b0, 10'h000));
        send_cmd(8'hFF);
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (!tx_error && w < INH + TMO + 100);
        check("t4_error_seen", 32'(tx_error), 32'd1);
        check("t4_timeout_cycles", 32'(cyc - req_cyc), 32'(TMO));
        @(posedge clk); #1;
        check("t4_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t4_data_oe", 32'(ps2_data_oe), 32'd0);
        repeat (5) @(negedge clk);

        // tx_valid held across a frame: the second frame waits for tx_ready.
        f0 = frame_cnt;
        exp_q.push_back(mk(1'b1, 1'b1, 10'h2F4));
        exp_q.push_back(mk(1'b1, 1'b1, 10'h2F4));
        @(negedge clk);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        dev_frame(10, 1'b1);
        wait_ready("t5_ready_mid");
        w = 0;
        while (!busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t5_second_accept", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        dev_frame(10, 1'b1);
        wait_ready("t5_ready_end");
        repeat (30) @(negedge clk);
        check("t5_frame_count", 32'(frame_cnt - f0), 32'd2);

        // Reset after the 4th data bit, then a clean frame.
        send_cmd(8'hED);
        dev_frame(4, 1'b1);
        check("t6_sending_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t6_data_oe", 32'(ps2_data_oe), 32'd0);
        check("t6_ready", 32'(tx_ready), 32'd1);
        repeat (50) @(negedge clk);
        exp_q.push_back(mk(1'b1, 1'b1, 10'h3ED));
        send_cmd(8'hED);
        dev_frame(10, 1'b1);
        wait_ready("t6_ready_end");
        repeat (20) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #(10 * 80000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

endmodule
